// File: rtl/hazard_flush_unit.sv
// Pipeline hazard control: operand forwarding, load-use and PC-write stalls/flushes,
// and a stall FSM that freezes the pipeline around multi-cycle vector memory accesses.
module hazard_flush_unit #(
  parameter int unsigned VMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       BranchTakenE,
  input  logic       VMemReqM,
  input  logic       VMemDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       VMemStart,
  output logic       VMemBusy,
  output logic       VMemErr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VMEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pcsrcm_q, pcsrcw_q;
  logic             vstall_c, start_c;
  logic             ldr_c, pcpend_c;

  // Forwarding select: the younger producer in M wins over W.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (RegWriteM && (ra == WA3M))      return 2'b10;
    else if (RegWriteW && (ra == WA3W)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(RA1E);
  assign ForwardBE = fwd_sel(RA2E);

  assign ldr_c    = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcpend_c = PCSrcD | PCSrcE | pcsrcm_q;

  // State register plus timeout counter and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; stall and start are decoded from the same transitions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    vstall_c = 1'b0;
    start_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (VMemReqM) begin
          vstall_c = 1'b1;
          start_c  = 1'b1;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (VMemDone) begin
          state_d = S_IDLE;
        end else begin
          vstall_c = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PC-write history follows the instruction through M and W, frozen with M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsrcm_q <= 1'b0;
      pcsrcw_q <= 1'b0;
    end else if (!StallM) begin
      pcsrcm_q <= PCSrcE;
      pcsrcw_q <= pcsrcm_q;
    end
  end

  // A vector stall freezes everything and defers branch/load-use effects.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      if (vstall_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_c | pcpend_c;
        StallD = ldr_c;
        FlushD = pcpend_c | pcsrcw_q | BranchTakenE;
        FlushE = ldr_c | BranchTakenE;
      end
    end
  end

  assign VMemStart = reset & start_c;
  assign VMemBusy  = (state_q == S_BUSY);
  assign VMemErr   = err_q;

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Bench for hazard_flush_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a rule-level behavioural model.
module tb_hazard_flush_unit;

  localparam int unsigned T = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, BranchTakenE;
  logic       VMemReqM, VMemDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       VMemStart, VMemBusy, VMemErr;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_flush_unit #(.VMEM_TIMEOUT(T), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
    .VMemReqM(VMemReqM), .VMemDone(VMemDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .VMemStart(VMemStart), .VMemBusy(VMemBusy), .VMemErr(VMemErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Behavioural model: memory-access phase, BUSY cycles waited, and PC writes seen by M/W.
  localparam int M_IDLE = 0, M_BUSY = 1, M_ERR = 2;
  int   m_mode = M_IDLE;
  int   m_waited = 0;
  bit   m_err = 0, m_pcm = 0, m_pcw = 0;

  function automatic logic [1:0] m_fwd(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2'd2;
    if (RegWriteW && ra == WA3W) return 2'd1;
    return 2'd0;
  endfunction

  logic [13:0] e_vec, a_vec;
  logic        e_ldr, e_pcp, e_vst, e_sf, e_sd, e_sm, e_fd, e_fe, e_fw, e_st, e_bz;

  // Compare process: checks every cycle, then advances the model across the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      m_mode = M_IDLE; m_waited = 0; m_err = 0; m_pcm = 0; m_pcw = 0;
    end
    e_ldr = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    e_pcp = PCSrcD || PCSrcE || m_pcm;
    e_vst = (m_mode == M_IDLE && VMemReqM) || (m_mode == M_BUSY && !VMemDone);
    e_sf = 0; e_sd = 0; e_sm = 0; e_fd = 0; e_fe = 0; e_fw = 0; e_st = 0;
    if (reset) begin
      if (e_vst) begin
        e_sf = 1; e_sd = 1; e_sm = 1; e_fw = 1;
      end else begin
        e_sf = e_ldr || e_pcp;
        e_sd = e_ldr;
        e_fd = e_pcp || m_pcw || BranchTakenE;
        e_fe = e_ldr || BranchTakenE;
      end
      e_st = (m_mode == M_IDLE) && VMemReqM;
    end
    e_bz = reset && (m_mode == M_BUSY);
    e_vec = {m_fwd(RA1E), m_fwd(RA2E), e_sf, e_sd, e_sm, e_sm, e_fd, e_fe, e_fw, e_st, e_bz, m_err};
    a_vec = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             VMemStart, VMemBusy, VMemErr};
    chk("model_outputs", 32'(a_vec), 32'(e_vec));
    if (reset) begin
      if (!e_vst) begin
        m_pcw = m_pcm;
        m_pcm = PCSrcE;
      end
      case (m_mode)
        M_IDLE: if (VMemReqM) begin m_mode = M_BUSY; m_waited = 0; end
        M_BUSY: begin
          if (VMemDone) m_mode = M_IDLE;
          else begin
            m_waited++;
            if (m_waited == T) begin m_mode = M_ERR; m_err = 1; end
          end
        end
        default: m_mode = M_ERR;
      endcase
    end
  end

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 4'hF; WA3M = 4'hE; WA3W = 4'hD;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCSrcD = 0; PCSrcE = 0;
    BranchTakenE = 0; VMemReqM = 0; VMemDone = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  logic [4:0] sf_pat = 5'b00111;
  logic [4:0] fd_pat = 5'b01111;
  int sfn, fdn, stn;

  initial begin
    clear_inputs();
    reset = 0;
    VMemReqM = 1;
    @(negedge clk);
    chk("rst_stallf", StallF, 0);
    chk("rst_start", VMemStart, 0);
    chk("rst_err", VMemErr, 0);
    next_cycle();
    reset = 1;
    clear_inputs();

    // Forwarding priority
    RegWriteM = 1; WA3M = 5; RegWriteW = 1; WA3W = 5; RA1E = 5; RA2E = 3;
    @(negedge clk);
    chk("fwdA_from_m", ForwardAE, 2'b10);
    chk("fwdB_none", ForwardBE, 2'b00);
    next_cycle();
    RegWriteM = 0;
    @(negedge clk);
    chk("fwdA_from_w", ForwardAE, 2'b01);
    next_cycle();
    clear_inputs();

    // Load-use
    MemtoRegE = 1; WA3E = 2; RA2D = 2; RA1D = 7;
    @(negedge clk);
    chk("ldr_stallf", StallF, 1);
    chk("ldr_stalld", StallD, 1);
    chk("ldr_flushe", FlushE, 1);
    chk("ldr_flushd", FlushD, 0);
    next_cycle();
    RA2D = 4;
    @(negedge clk);
    chk("noldr_stallf", StallF, 0);
    chk("noldr_stalld", StallD, 0);
    chk("noldr_flushe", FlushE, 0);
    next_cycle();
    clear_inputs();

    // PC write walking D -> E -> M -> W
    sfn = 0; fdn = 0;
    for (int i = 0; i < 5; i++) begin
      PCSrcD = (i == 0);
      PCSrcE = (i == 1);
      @(negedge clk);
      chk($sformatf("pc_stallf_c%0d", i), StallF, sf_pat[i]);
      chk($sformatf("pc_flushd_c%0d", i), FlushD, fd_pat[i]);
      sfn += int'(StallF);
      fdn += int'(FlushD);
      next_cycle();
    end
    chk("pc_stallf_total", sfn, 3);
    chk("pc_flushd_total", fdn, 4);
    clear_inputs();

    // Vector access completing on the fifth BUSY cycle
    for (int i = 0; i < 7; i++) begin
      VMemReqM = (i == 0);
      VMemDone = (i == 5);
      @(negedge clk);
      chk($sformatf("vm_start_c%0d", i), VMemStart, (i == 0));
      chk($sformatf("vm_stall_c%0d", i), StallF, (i < 5));
      chk($sformatf("vm_stallm_c%0d", i), StallM, (i < 5));
      chk($sformatf("vm_flushw_c%0d", i), FlushW, (i < 5));
      chk($sformatf("vm_busy_c%0d", i), VMemBusy, (i >= 1 && i <= 5));
      next_cycle();
    end
    clear_inputs();

    // Request held across done re-arms through one IDLE cycle
    for (int i = 0; i < 6; i++) begin
      VMemReqM = (i <= 3);
      VMemDone = (i == 2 || i == 5);
      @(negedge clk);
      chk($sformatf("rearm_start_c%0d", i), VMemStart, (i == 0 || i == 3));
      chk($sformatf("rearm_stall_c%0d", i), StallD, (i == 0 || i == 1 || i == 3 || i == 4));
      next_cycle();
    end
    clear_inputs();

    // Branch while BUSY is deferred until the done cycle
    for (int i = 0; i < 5; i++) begin
      VMemReqM = (i == 0);
      BranchTakenE = (i >= 1 && i <= 3);
      VMemDone = (i == 3);
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        chk($sformatf("br_flushd_c%0d", i), FlushD, (i == 3));
        chk($sformatf("br_flushe_c%0d", i), FlushE, (i == 3));
      end
      next_cycle();
    end
    clear_inputs();

    // Timeout into sticky ERROR
    stn = 0;
    for (int i = 0; i < int'(T) + 4; i++) begin
      VMemReqM = 1;
      @(negedge clk);
      stn += int'(StallF);
      next_cycle();
    end
    @(negedge clk);
    chk("to_stall_cycles", stn, 1 + T);
    chk("to_err_sticky", VMemErr, 1);
    chk("to_no_start", VMemStart, 0);
    chk("to_no_stall", StallF, 0);
    next_cycle();

    // Asynchronous reset clears ERROR
    #2 reset = 0;
    #1;
    chk("arst_err_clear", VMemErr, 0);
    chk("arst_stall_zero", StallF, 0);
    next_cycle();
    reset = 1;
    next_cycle();
    @(negedge clk);
    chk("busy_before_rst", VMemBusy, 1);
    chk("stall_before_rst", StallM, 1);
    next_cycle();
    #2 reset = 0;
    #1;
    chk("arst_busy_zero", VMemBusy, 0);
    chk("arst_stallm_zero", StallM, 0);
    chk("arst_flushw_zero", FlushW, 0);
    chk("arst_start_zero", VMemStart, 0);
    next_cycle();
    reset = 1;
    clear_inputs();

    // Randomized traffic, checked by the compare process each cycle
    for (int n = 0; n < 3000; n++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 5) == 0);
      PCSrcE = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      VMemReqM = ($urandom_range(0, 3) == 0);
      VMemDone = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 49) != 0);
      next_cycle();
    end
    reset = 1;
    clear_inputs();
    @(negedge clk);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_flush_unit.md
Name: hazard_flush_unit

Overview:
- Pipeline control counterpart to the execute-stage condition logic.
- Consumes the condition-gated outputs (RegWrite, PCSrc, BranchTakenE, vector memory requests) and the decoded register addresses.
- Produces forwarding selects, stage stalls/flushes, and a multi-cycle stall FSM for vector memory accesses.
- Internally tracks in-flight PC writes through M and W.

Parameters:
VMEM_TIMEOUT, 64, max BUSY cycles waiting for VMemDone before entering ERROR (≥2)
CNT_W, 7, width of timeout counter (must hold VMEM_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
RA1D, RA2D  in  4  source registers in Decode
RA1E, RA2E  in  4  source registers in Execute
WA3E, WA3M, WA3W  in  4  destination registers in E/M/W
RegWriteM, RegWriteW  in  1  condition-gated scalar register writes in M/W
MemtoRegE  in  1  load in Execute
PCSrcD  in  1  decoded instruction writes PC
PCSrcE  in  1  condition-gated PC write from Execute
BranchTakenE  in  1  condition-gated branch taken
VMemReqM  in  1  vector memory access in Memory stage
VMemDone  in  1  vector memory completion, single-cycle pulse
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  bubble into stage register
VMemStart  out  1  one-cycle start pulse to vector memory
VMemBusy  out  1  FSM in BUSY
VMemErr  out  1  sticky timeout error

Behaviour:
- Reset (reset=0, async):
  - State=IDLE, counter=0, PCSrcM_q=0, PCSrcW_q=0, VMemErr=0.
  - All stall/flush/start outputs are 0; ForwardAE/BE follow the combinational rule.
- Forwarding (combinational, per operand):
  - 10 if RegWriteM and RAxE==WA3M.
  - Else 01 if RegWriteW and RAxE==WA3W.
  - Else 00.
  - M takes priority over W when both match.
- Load-use: ldr = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- PC tracking flops:
  - PCSrcM_q<=PCSrcE and PCSrcW_q<=PCSrcM_q each cycle unless StallM=1; while StallM=1 both hold.
  - pcpend = PCSrcD | PCSrcE | PCSrcM_q.
- vstall = (state==IDLE & VMemReqM) | (state==BUSY & ~VMemDone).
- Outputs when vstall=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - BranchTakenE and ldr effects are deferred until the stall releases.
- Outputs when vstall=0:
  - StallF = ldr | pcpend; StallD = ldr; StallE=StallM=FlushW=0.
  - FlushD = pcpend | PCSrcW_q | BranchTakenE.
  - FlushE = ldr | BranchTakenE.
- FSM:
  - IDLE: VMemReqM → VMemStart=1 for exactly this cycle, counter<=0, next BUSY.
  - BUSY: VMemBusy=1.
    - VMemDone → stall drops in that same cycle, next IDLE.
    - Else if counter==VMEM_TIMEOUT-1 → next ERROR, VMemErr<=1.
    - Else counter++.
  - ERROR: no stalls from the FSM, VMemErr held 1, VMemReqM ignored; leaves only via reset.
  - VMemDone in IDLE or ERROR is ignored.
- VMemReqM held high after done: a new request is accepted only after one IDLE cycle (re-arm requires IDLE).
- Latency:
  - Stall and flush outputs are combinational from inputs and state, with no added cycle.
  - VMemStart rises in the cycle the request is seen.
- Mid-operation reset: FSM returns to IDLE immediately, stalls drop, and the error clears.

Test Plan:
- RegWriteM=1, WA3M=5, RegWriteW=1, WA3W=5, RA1E=5, RA2E=3 → ForwardAE=10, ForwardBE=00; clear RegWriteM → ForwardAE=01.
- MemtoRegE=1, WA3E=2, RA2D=2 → StallF=StallD=FlushE=1, FlushD=0 for one cycle; change RA2D=4 → all 0.
- PCSrcD=1 for one cycle with an advancing pipeline, PCSrcE=1 next cycle → StallF=1 for 3 consecutive cycles (D, E, M_q) and FlushD=1 for 4 (incl. PCSrcW_q cycle).
- VMemReqM=1, VMemDone pulses 5 cycles later → VMemStart=1 for cycle 0 only, stalls high cycles 0–4, low in the done cycle, FlushW mirrors stall, state back to IDLE.
- VMEM_TIMEOUT=4, VMemReqM=1, no done → stalls high 5 cycles (IDLE + 4 BUSY), then VMemErr=1 sticky, stalls 0, further VMemReqM gives no VMemStart.
- BranchTakenE=1 while BUSY → FlushD=FlushE=0 until done; in the done cycle FlushD=FlushE=1. Assert reset low mid-BUSY → all outputs 0 asynchronously.
